frame_sequencer: RTL and testbench

Playback controller for the 8x8 LED matrix scan path. It stores up to NUM_FRAMES 8x8 bitmaps written by a host and presents the row selected by the scan block's row index. It steps through the stored frames with a fade-in / hold / fade-out brightness envelope. Its frame_data and brightness outputs drive the scan block's frame_data and brightness inputs directly.

---
 rtl/display_pkg.sv | 23 ++
 rtl/tick_gen.sv | 38 +++
 rtl/frame_sequencer.sv | 177 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared types and constants for the LED matrix display path
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int PWM_WIDTH_DEFAULT = 8;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    HOLD     = 3'd2,
    FADE_OUT = 3'd3,
    SWAP     = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : free-running prescaler, one-cycle tick every TICK_DIV clocks
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == c_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ============================================================================
// frame_sequencer : frame store plus fade-in / hold / fade-out playback FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_sequencer
  import display_pkg::*;
#(
  parameter int PWM_WIDTH  = PWM_WIDTH_DEFAULT,
  parameter int NUM_FRAMES = 4,
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 500,
  parameter int FADE_STEP  = 8,
  localparam int FW        = $clog2(NUM_FRAMES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FW-1:0]        wr_frame,
  input  logic [2:0]           wr_row,
  input  logic [COLS-1:0]      wr_data,
  input  logic                 play_en,
  input  logic [FW:0]          frames_active,
  input  logic [PWM_WIDTH-1:0] max_brightness,
  input  logic [2:0]           row_idx,
  output logic [COLS-1:0]      frame_data,
  output logic [PWM_WIDTH-1:0] brightness,
  output logic [FW-1:0]        cur_frame,
  output logic                 playing
);

  localparam logic [2:0] c_ST_IDLE     = IDLE;
  localparam logic [2:0] c_ST_FADE_IN  = FADE_IN;
  localparam logic [2:0] c_ST_HOLD     = HOLD;
  localparam logic [2:0] c_ST_FADE_OUT = FADE_OUT;
  localparam logic [2:0] c_ST_SWAP     = SWAP;

  localparam int c_HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int c_BW = PWM_WIDTH + 1;
  localparam logic [c_BW-1:0] c_STEP      = c_BW'(FADE_STEP);
  localparam logic [FW:0]     c_NF        = (FW+1)'(NUM_FRAMES);
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_TICKS - 1);

  logic                 w_tick;
  logic [2:0]           r_state;
  logic [PWM_WIDTH-1:0] r_bright;
  logic [FW-1:0]        r_cur;
  logic [c_HW-1:0]      r_hold;
  logic [COLS-1:0]      r_frame_data;
  logic [COLS-1:0]      r_mem [NUM_FRAMES*ROWS];

  logic                 w_playing;
  logic                 w_wr_ready;
  logic [FW:0]          w_n;
  logic [FW:0]          w_next_inc;
  logic [c_BW-1:0]      w_bright_ext;
  logic [c_BW-1:0]      w_max_ext;
  logic [c_BW-1:0]      w_up;
  logic [c_BW-1:0]      w_down;
  logic [PWM_WIDTH-1:0] w_fade_in_val;
  logic [PWM_WIDTH-1:0] w_fade_out_val;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_comb begin
    w_n = frames_active;
    if (frames_active == '0) begin
      w_n = (FW+1)'(1);
    end else if (frames_active > c_NF) begin
      w_n = c_NF;
    end
    w_next_inc   = {1'b0, r_cur} + (FW+1)'(1);
    // One extra bit so the up/down steps saturate instead of wrapping
    w_bright_ext = {1'b0, r_bright};
    w_max_ext    = {1'b0, max_brightness};
    w_up         = w_bright_ext + c_STEP;
    w_down       = w_bright_ext - c_STEP;
    w_fade_in_val  = (w_up > w_max_ext) ? max_brightness : w_up[PWM_WIDTH-1:0];
    w_fade_out_val = (w_bright_ext >= c_STEP) ? w_down[PWM_WIDTH-1:0] : '0;
  end

  assign w_playing  = (r_state != c_ST_IDLE);
  assign w_wr_ready = !(w_playing && (wr_frame == r_cur));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_bright <= '0;
      r_cur    <= '0;
      r_hold   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_bright <= '0;
          if (play_en) begin
            r_cur   <= '0;
            r_state <= c_ST_FADE_IN;
          end
        end
        c_ST_FADE_IN: begin
          if (!play_en) begin
            r_state <= c_ST_FADE_OUT;
          end else if (r_bright > max_brightness) begin
            r_bright <= max_brightness;
          end else if (w_tick) begin
            if (r_bright == max_brightness) begin
              r_state <= c_ST_HOLD;
              r_hold  <= '0;
            end else begin
              r_bright <= w_fade_in_val;
            end
          end
        end
        c_ST_HOLD: begin
          r_bright <= max_brightness;
          if (!play_en) begin
            r_state <= c_ST_FADE_OUT;
          end else if (w_tick) begin
            if (r_hold == c_HOLD_LAST) begin
              r_state <= c_ST_FADE_OUT;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        c_ST_FADE_OUT: begin
          if (w_tick) begin
            if (r_bright == '0) begin
              r_state <= play_en ? c_ST_SWAP : c_ST_IDLE;
            end else begin
              r_bright <= w_fade_out_val;
            end
          end
        end
        c_ST_SWAP: begin
          r_cur   <= (w_next_inc >= w_n) ? '0 : w_next_inc[FW-1:0];
          r_state <= play_en ? c_ST_FADE_IN : c_ST_FADE_OUT;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Frame store is deliberately not reset so host content survives a reset
  always_ff @(posedge clk) begin
    if (wr_valid && w_wr_ready) begin
      r_mem[{wr_frame, wr_row}] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_data <= '0;
    end else begin
      r_frame_data <= r_mem[{r_cur, row_idx}];
    end
  end

  assign wr_ready   = w_wr_ready;
  assign frame_data = r_frame_data;
  assign brightness = r_bright;
  assign cur_frame  = r_cur;
  assign playing    = w_playing;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================================
// tb_frame_sequencer : directed self-checking bench for frame_sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_sequencer;
  import display_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_frame;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       play_en;
  logic [2:0] frames_active;
  logic [7:0] max_brightness;
  logic [2:0] row_idx;
  logic [7:0] frame_data;
  logic [7:0] brightness;
  logic [1:0] cur_frame;
  logic       playing;

  int n_asserts = 0;
  int n_fails   = 0;

  frame_sequencer #(
    .PWM_WIDTH  (8),
    .NUM_FRAMES (4),
    .TICK_DIV   (4),
    .HOLD_TICKS (3),
    .FADE_STEP  (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_frame       (wr_frame),
    .wr_row         (wr_row),
    .wr_data        (wr_data),
    .play_en        (play_en),
    .frames_active  (frames_active),
    .max_brightness (max_brightness),
    .row_idx        (row_idx),
    .frame_data     (frame_data),
    .brightness     (brightness),
    .cur_frame      (cur_frame),
    .playing        (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] f, input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_frame = f;
    wr_row   = r;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_change(input int limit, output logic [7:0] val);
    logic [7:0] old;
    int cyc;
    old = brightness;
    cyc = 0;
    while (brightness === old && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    val = brightness;
  endtask

  task automatic wait_bright(input logic [7:0] target, input int limit, output logic ok);
    int cyc;
    cyc = 0;
    while (brightness !== target && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    ok = (brightness === target);
  endtask

  task automatic wait_frame(input int limit, output logic [1:0] val);
    logic [1:0] old;
    int cyc;
    old = cur_frame;
    cyc = 0;
    while (cur_frame === old && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    val = cur_frame;
  endtask

  initial begin
    logic [7:0] pat [4];
    logic [7:0] b;
    logic [1:0] f;
    logic       ok;
    logic       saw_lit;
    logic       saw_swap;
    logic [1:0] f0;
    int         hold_cyc;
    int         cyc;

    pat[0] = 8'h81; pat[1] = 8'h3C; pat[2] = 8'h5A; pat[3] = 8'hF0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_frame = '0; wr_row = '0; wr_data = '0;
    play_en = 1'b0; frames_active = 3'd2; max_brightness = 8'd200; row_idx = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_brightness", brightness, 0);
    chk("rst_frame_data", frame_data, 0);
    chk("rst_cur_frame", cur_frame, 0);
    chk("rst_playing", playing, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;

    // Load all slots while idle
    for (int fi = 0; fi < 4; fi++) begin
      for (int ri = 0; ri < 8; ri++) begin
        host_write(fi[1:0], ri[2:0], pat[fi]);
      end
    end
    @(negedge clk);
    wr_frame = 2'd0;
    #1 chk("idle_wr_ready", wr_ready, 1);
    row_idx = 3'd3;
    repeat (2) @(negedge clk);
    chk("idle_read_f0", frame_data, 8'h81);

    // Envelope on frame 0
    play_en = 1'b1;
    @(negedge clk);
    chk("play_playing", playing, 1);
    chk("play_bright0", brightness, 0);
    wait_change(20, b); chk("env_64", b, 64);
    wait_change(20, b); chk("env_128", b, 128);
    wait_change(20, b); chk("env_192", b, 192);
    wait_change(20, b); chk("env_200", b, 200);
    hold_cyc = 0;
    while (brightness === 8'd200 && hold_cyc < 60) begin
      @(negedge clk);
      hold_cyc++;
    end
    chk("env_hold_min", (hold_cyc >= 12), 1);
    chk("env_hold_max", (hold_cyc <= 24), 1);
    chk("env_136", brightness, 136);
    wait_change(20, b); chk("env_72", b, 72);
    wait_change(20, b); chk("env_8", b, 8);
    wait_change(20, b); chk("env_0", b, 0);
    wait_frame(40, f); chk("swap_0_to_1", f, 1);

    // Write blocking while frame 1 is displayed
    @(negedge clk);
    wr_valid = 1'b1; wr_frame = 2'd1; wr_row = 3'd0; wr_data = 8'hFF;
    #1 chk("blocked_wr_ready", wr_ready, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    row_idx = 3'd0;
    repeat (2) @(negedge clk);
    chk("blocked_mem_kept", frame_data, 8'h3C);
    wr_valid = 1'b1; wr_frame = 2'd2; wr_row = 3'd5; wr_data = 8'hA5;
    #1 chk("other_wr_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;

    wait_frame(150, f); chk("wrap_1_to_0", f, 0);

    // frames_active=7 clamps to 4 slots
    frames_active = 3'd7;
    wait_frame(150, f); chk("loop4_f1", f, 1);
    wait_frame(150, f); chk("loop4_f2", f, 2);
    row_idx = 3'd5;
    repeat (2) @(negedge clk);
    chk("written_A5", frame_data, 8'hA5);
    wait_frame(150, f); chk("loop4_f3", f, 3);
    repeat (2) @(negedge clk);
    chk("f3_row5", frame_data, 8'hF0);
    wait_frame(150, f); chk("loop4_wrap", f, 0);

    // frames_active=0 behaves as one slot
    frames_active = 3'd0;
    wait_bright(8'd200, 150, ok); chk("n1_reach200", ok, 1);
    wait_bright(8'd0, 150, ok);   chk("n1_reach0", ok, 1);
    wait_bright(8'd64, 150, ok);  chk("n1_next_env", ok, 1);
    chk("n1_cur_frame", cur_frame, 0);

    // Stop from HOLD on frame 1
    frames_active = 3'd2;
    wait_frame(150, f); chk("stop_pre_f1", f, 1);
    wait_bright(8'd200, 150, ok); chk("stop_reach200", ok, 1);
    repeat (6) @(negedge clk);
    play_en = 1'b0;
    @(negedge clk);
    chk("stop_state", dut.r_state, FADE_OUT);
    chk("stop_bright200", brightness, 200);
    wait_change(20, b); chk("stop_136", b, 136);
    wait_change(20, b); chk("stop_72", b, 72);
    wait_change(20, b); chk("stop_8", b, 8);
    wait_change(20, b); chk("stop_0", b, 0);
    cyc = 0;
    while (playing === 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stop_playing", playing, 0);
    repeat (10) @(negedge clk);
    chk("stop_no_swap", cur_frame, 1);
    chk("stop_idle_bright", brightness, 0);

    // Ceiling clamp during FADE_IN
    play_en = 1'b1;
    @(negedge clk);
    chk("restart_frame0", cur_frame, 0);
    wait_bright(8'd128, 40, ok); chk("clamp_reach128", ok, 1);
    max_brightness = 8'd100;
    @(negedge clk);
    chk("clamp_100", brightness, 100);

    // Zero ceiling: dark, but frames still advance
    max_brightness = 8'd0;
    repeat (2) @(negedge clk);
    f0 = cur_frame;
    saw_lit = 1'b0;
    saw_swap = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (brightness !== 8'd0) saw_lit = 1'b1;
      if (cur_frame !== f0) saw_swap = 1'b1;
    end
    chk("zero_dark", saw_lit, 0);
    chk("zero_swaps", saw_swap, 1);
    chk("zero_playing", playing, 1);

    // Asynchronous reset mid-HOLD
    max_brightness = 8'd200;
    wait_bright(8'd200, 200, ok); chk("rst2_reach200", ok, 1);
    repeat (6) @(negedge clk);
    wr_frame = cur_frame;
    #1 chk("rst2_pre_ready", wr_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_brightness", brightness, 0);
    chk("rst2_state", dut.r_state, IDLE);
    chk("rst2_cur_frame", cur_frame, 0);
    chk("rst2_playing", playing, 0);
    chk("rst2_wr_ready", wr_ready, 1);
    chk("rst2_frame_data", frame_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    row_idx = 3'd2;
    repeat (3) @(negedge clk);
    chk("rst2_mem_kept", frame_data, 8'h81);
    chk("rst2_replay", playing, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
